// File: rtl/debug_frame_tx.sv
// Serializes a captured debug snapshot into SOF + MSB-first payload bytes for uart_tx.
// Optional trailing XOR checksum byte is enabled with `define DEBUG_FRAME_CHECKSUM_EN.
module debug_frame_tx #(
    parameter int                 NB_DATA  = 8,
    parameter int                 NB_FRAME = 144,
    parameter logic [NB_DATA-1:0] SOF      = 8'hA5
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_send,
    input  logic [NB_FRAME-1:0] i_frame,
    input  logic                i_txDone,
    output logic                o_tx_start,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_busy,
    output logic                o_frame_done
);

    localparam int NBYTES = NB_FRAME / NB_DATA;
    localparam int CNT_W  = $clog2(NBYTES + 2);

`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES + 1);
`else
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [NB_FRAME-1:0] shadow_r, shadow_s;
    logic [NB_DATA-1:0]  data_r, data_s;
    logic                tx_start_r, tx_start_s;
    logic                busy_r, busy_s;
    logic                frame_done_r, frame_done_s;

    // Payload index k (1..NBYTES) selects the k-th byte counting from the MSB end.
    function automatic logic [NB_DATA-1:0] payload_byte(input logic [NB_FRAME-1:0] frame,
                                                        input logic [CNT_W-1:0]    idx);
        logic [NB_DATA-1:0] sel;
        sel = {NB_DATA{1'b0}};
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == CNT_W'(i + 1)) begin
                sel = frame[NB_FRAME-1-i*NB_DATA -: NB_DATA];
            end
        end
        return sel;
    endfunction

`ifdef DEBUG_FRAME_CHECKSUM_EN
    logic [NB_DATA-1:0] csum_r, csum_s;

    function automatic logic [NB_DATA-1:0] csum_update(input logic [NB_DATA-1:0] acc,
                                                       input logic [NB_DATA-1:0] data);
        return acc ^ data;
    endfunction
`endif

    // Next-state, counter and shadow-register logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        shadow_s = shadow_r;
        case (state_r)
            IDLE: begin
                if (i_send) begin
                    shadow_s = i_frame;
                    cnt_s    = {CNT_W{1'b0}};
                    state_s  = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: state_s = WAIT;
            WAIT: begin
                if (i_txDone) begin
                    state_s = NEXT;
                end else begin
                    state_s = WAIT;
                end
            end
            NEXT: begin
                // Saturate at the final index so the counter never runs past the frame.
                if (cnt_r == LAST_IDX) begin
                    state_s = DONE;
                end else begin
                    cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_s = START;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode; o_data is only reloaded on entry to START so it stays put while in flight.
    always_comb begin
        tx_start_s   = (state_s == START);
        busy_s       = (state_s == START) || (state_s == WAIT) || (state_s == NEXT);
        frame_done_s = (state_s == DONE);
        data_s       = data_r;
        if (state_s == START) begin
            if (cnt_s == {CNT_W{1'b0}}) begin
                data_s = SOF;
`ifdef DEBUG_FRAME_CHECKSUM_EN
            end else if (cnt_s == LAST_IDX) begin
                data_s = csum_r;
`endif
            end else begin
                data_s = payload_byte(shadow_s, cnt_s);
            end
        end else begin
            data_s = data_r;
        end
    end

`ifdef DEBUG_FRAME_CHECKSUM_EN
    // Checksum accumulates each payload byte as it is loaded for transmission.
    always_comb begin
        csum_s = csum_r;
        if ((state_r == IDLE) && i_send) begin
            csum_s = {NB_DATA{1'b0}};
        end else if ((state_r == NEXT) && (state_s == START)) begin
            csum_s = csum_update(csum_r, payload_byte(shadow_r, cnt_s));
        end else begin
            csum_s = csum_r;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            csum_r <= {NB_DATA{1'b0}};
        end else begin
            csum_r <= csum_s;
        end
    end
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            shadow_r     <= {NB_FRAME{1'b0}};
            data_r       <= {NB_DATA{1'b0}};
            tx_start_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            shadow_r     <= shadow_s;
            data_r       <= data_s;
            tx_start_r   <= tx_start_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign o_tx_start   = tx_start_r;
    assign o_data       = data_r;
    assign o_busy       = busy_r;
    assign o_frame_done = frame_done_r;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx (NB_FRAME=32) with a uart_tx model answering 10 cycles after each start.
module tb_debug_frame_tx;

`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam int NEXP = 6;
`else
    localparam int NEXP = 5;
`endif

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_send;
    logic [31:0] i_frame;
    logic        i_txDone;
    logic        o_tx_start;
    logic [7:0]  o_data;
    logic        o_busy;
    logic        o_frame_done;

    logic        model_done = 1'b0;
    logic        stray_done = 1'b0;
    int          model_cnt  = 0;
    assign i_txDone = model_done | stray_done;

    int tests_run = 0;
    int tests_failed = 0;

    int          cyc = 0;
    logic [7:0]  byte_log [0:127];
    int          start_cyc_log [0:127];
    int          nbytes = 0;
    int          fd_cnt = 0;
    int          last_fd_gap = 0;
    int          stab_err = 0;
    int          gap_err = 0;
    int          pulse_err = 0;
    bit          inflight = 0;
    bit          pending = 0;
    bit          prev_start = 0;
    int          done_cyc = 0;
    logic [7:0]  held = 8'h00;

    debug_frame_tx #(.NB_DATA(8), .NB_FRAME(32), .SOF(8'hA5)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_send       (i_send),
        .i_frame      (i_frame),
        .i_txDone     (i_txDone),
        .o_tx_start   (o_tx_start),
        .o_data       (o_data),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: done pulse 10 cycles after the cycle o_tx_start is high
    always @(posedge clk) begin
        #1;
        if (o_tx_start === 1'b1) begin
            model_cnt  = 10;
            model_done = 1'b0;
        end else if (model_cnt > 0) begin
            model_cnt  = model_cnt - 1;
            model_done = (model_cnt == 0);
        end else begin
            model_done = 1'b0;
        end
    end

    // Stream monitor: logs bytes and records timing/stability observations
    always @(negedge clk) begin
        if (inflight && o_busy === 1'b1 && o_data !== held) stab_err++;
        if (inflight && i_txDone === 1'b1) begin
            inflight = 0;
            pending  = 1;
            done_cyc = cyc;
        end
        if (o_busy !== 1'b1) begin
            inflight = 0;
            pending  = 0;
        end
        if (o_tx_start === 1'b1) begin
            if (prev_start) pulse_err++;
            if (pending && (cyc - done_cyc) != 2) gap_err++;
            pending  = 0;
            held     = o_data;
            inflight = 1;
            if (nbytes < 128) begin
                byte_log[nbytes]      = o_data;
                start_cyc_log[nbytes] = cyc;
            end
            nbytes++;
        end
        prev_start = (o_tx_start === 1'b1);
        if (o_frame_done === 1'b1) begin
            fd_cnt++;
            last_fd_gap = cyc - done_cyc;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] f, input int k);
        case (k)
            0:       return 8'hA5;
            1:       return f[31:24];
            2:       return f[23:16];
            3:       return f[15:8];
            4:       return f[7:0];
            default: return f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
        endcase
    endfunction

    task automatic send(input logic [31:0] f);
        @(posedge clk); #1;
        i_send  = 1'b1;
        i_frame = f;
        @(posedge clk); #1;
        i_send  = 1'b0;
    endtask

    task automatic wait_fd(input int fd0, output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (fd_cnt > fd0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (nbytes >= target) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0; i_send = 1'b0; i_frame = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (o_tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start got=%b exp=0", o_tx_start); end
        tests_run++; if (o_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got=%h exp=00", o_data); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        tests_run++; if (o_frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got=%b exp=0", o_frame_done); end
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (nbytes !== 0) begin tests_failed++; $display("FAIL reset_idle_starts got=%0d exp=0", nbytes); end
    endtask

    task automatic test_basic;
        int base = nbytes;
        int fd0 = fd_cnt;
        bit ok;
        send(32'h12345678);
        wait_fd(fd0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_timeout got=no frame_done exp=frame_done"); end
        repeat (3) @(negedge clk);
        tests_run++; if (nbytes - base !== NEXP) begin tests_failed++; $display("FAIL basic_count got=%0d exp=%0d", nbytes - base, NEXP); end
        for (int k = 0; k < NEXP; k++) begin
            tests_run++;
            if (byte_log[base+k] !== exp_byte(32'h12345678, k)) begin
                tests_failed++; $display("FAIL basic_byte%0d got=%h exp=%h", k, byte_log[base+k], exp_byte(32'h12345678, k));
            end
        end
        tests_run++; if (fd_cnt - fd0 !== 1) begin tests_failed++; $display("FAIL basic_fd_count got=%0d exp=1", fd_cnt - fd0); end
        // last i_txDone in cycle c -> NEXT in c+1 -> DONE/o_frame_done in c+2
        tests_run++; if (last_fd_gap !== 2) begin tests_failed++; $display("FAIL basic_fd_latency got=%0d exp=2", last_fd_gap); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_after got=%b exp=0", o_busy); end
    endtask

    task automatic test_coherence;
        int base = nbytes;
        int fd0 = fd_cnt;
        bit ok;
        send(32'h12345678);
        wait_bytes(base + 2, ok);
        @(posedge clk); #1;
        i_frame = 32'hDEADBEEF;
        i_send  = 1'b1;
        @(posedge clk); #1;
        i_send  = 1'b0;
        wait_fd(fd0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL coher_timeout got=no frame_done exp=frame_done"); end
        repeat (30) @(negedge clk);
        tests_run++; if (nbytes - base !== NEXP) begin tests_failed++; $display("FAIL coher_count got=%0d exp=%0d", nbytes - base, NEXP); end
        for (int k = 0; k < NEXP; k++) begin
            tests_run++;
            if (byte_log[base+k] !== exp_byte(32'h12345678, k)) begin
                tests_failed++; $display("FAIL coher_byte%0d got=%h exp=%h", k, byte_log[base+k], exp_byte(32'h12345678, k));
            end
        end
        tests_run++; if (fd_cnt - fd0 !== 1) begin tests_failed++; $display("FAIL coher_fd_count got=%0d exp=1", fd_cnt - fd0); end
    endtask

    task automatic test_stray_done;
        int base = nbytes;
        int fd0 = fd_cnt;
        bit ok;
        @(posedge clk); #1; stray_done = 1'b1;
        @(posedge clk); #1; stray_done = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++; if (nbytes !== base) begin tests_failed++; $display("FAIL stray_idle_starts got=%0d exp=%0d", nbytes, base); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL stray_idle_busy got=%b exp=0", o_busy); end
        // send with a coincident done in IDLE, then another done in the START cycle
        @(posedge clk); #1;
        i_send = 1'b1; i_frame = 32'hCAFE0102; stray_done = 1'b1;
        @(posedge clk); #1;
        i_send = 1'b0;
        @(posedge clk); #1;
        stray_done = 1'b0;
        wait_fd(fd0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL stray_timeout got=no frame_done exp=frame_done"); end
        repeat (3) @(negedge clk);
        tests_run++; if (nbytes - base !== NEXP) begin tests_failed++; $display("FAIL stray_count got=%0d exp=%0d", nbytes - base, NEXP); end
        for (int k = 0; k < NEXP; k++) begin
            tests_run++;
            if (byte_log[base+k] !== exp_byte(32'hCAFE0102, k)) begin
                tests_failed++; $display("FAIL stray_byte%0d got=%h exp=%h", k, byte_log[base+k], exp_byte(32'hCAFE0102, k));
            end
        end
    endtask

    task automatic test_reset_mid;
        int base = nbytes;
        int fd0 = fd_cnt;
        bit ok;
        send(32'h12345678);
        wait_bytes(base + 3, ok);
        repeat (3) @(posedge clk);
        #1; i_rst_n = 1'b0;
        @(posedge clk); #1; i_rst_n = 1'b1;
        @(negedge clk);
        tests_run++; if ({o_tx_start, o_busy, o_frame_done} !== 3'b000 || o_data !== 8'h00) begin
            tests_failed++; $display("FAIL midrst_outputs got=%b%b%b/%h exp=000/00", o_tx_start, o_busy, o_frame_done, o_data);
        end
        repeat (30) @(negedge clk);
        tests_run++; if (fd_cnt !== fd0) begin tests_failed++; $display("FAIL midrst_no_fd got=%0d exp=%0d", fd_cnt, fd0); end
        tests_run++; if (nbytes - base !== 3) begin tests_failed++; $display("FAIL midrst_aborted got=%0d exp=3", nbytes - base); end
        base = nbytes;
        send(32'h00FF8001);
        wait_fd(fd0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL midrst_timeout got=no frame_done exp=frame_done"); end
        for (int k = 0; k < NEXP; k++) begin
            tests_run++;
            if (byte_log[base+k] !== exp_byte(32'h00FF8001, k)) begin
                tests_failed++; $display("FAIL midrst_byte%0d got=%h exp=%h", k, byte_log[base+k], exp_byte(32'h00FF8001, k));
            end
        end
    endtask

    task automatic test_back_to_back;
        int base = nbytes;
        int fd0 = fd_cnt;
        int s_cyc;
        bit ok = 0;
        send(32'h12345678);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (o_frame_done === 1'b1) begin ok = 1; break; end
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_first_timeout got=no frame_done exp=frame_done"); end
        @(posedge clk); #1;
        i_send = 1'b1; i_frame = 32'h00FF8001; s_cyc = cyc;
        @(posedge clk); #1;
        i_send = 1'b0;
        wait_fd(fd0 + 1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_second_timeout got=no frame_done exp=frame_done"); end
        repeat (3) @(negedge clk);
        tests_run++; if (nbytes - base !== 2 * NEXP) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=%0d", nbytes - base, 2 * NEXP); end
        tests_run++; if (start_cyc_log[base+NEXP] - s_cyc !== 1) begin
            tests_failed++; $display("FAIL b2b_start_latency got=%0d exp=1", start_cyc_log[base+NEXP] - s_cyc);
        end
        for (int k = 0; k < NEXP; k++) begin
            tests_run++;
            if (byte_log[base+NEXP+k] !== exp_byte(32'h00FF8001, k)) begin
                tests_failed++; $display("FAIL b2b_byte%0d got=%h exp=%h", k, byte_log[base+NEXP+k], exp_byte(32'h00FF8001, k));
            end
        end
        tests_run++; if (stab_err !== 0) begin tests_failed++; $display("FAIL data_stable got=%0d exp=0", stab_err); end
        tests_run++; if (gap_err !== 0) begin tests_failed++; $display("FAIL done_to_start_gap got=%0d exp=0", gap_err); end
        tests_run++; if (pulse_err !== 0) begin tests_failed++; $display("FAIL start_pulse_width got=%0d exp=0", pulse_err); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_coherence;
        test_stray_done;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
